heartbeat_gen: RTL and testbench

Liveness-qualified heartbeat source for the AM radio FPGA watchdog path. The watchdog monitors `heartbeat`; this block drives it. It emits a one-cycle `heartbeat` pulse once per window of `PERIOD` cycles, but only if the control path proved itself alive during that window by pulsing `alive`. A hung control path therefore starves the watchdog and lets it fire. The block also answers the watchdog's `warning` with an early beat, and reports persistent starvation on `stalled`.

---
 rtl/heartbeat_gen.sv | 178 +++++++++++++++++
 tb/tb_heartbeat_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_gen.sv
// -----------------------------------------------------------------------------
// heartbeat_gen
//
// Liveness-qualified heartbeat source for the watchdog path. Once per window
// of PERIOD cycles a one-cycle heartbeat pulse is emitted, but only if the
// control path pulsed `alive` during that window. A rising edge on the
// watchdog's `warning` produces an early beat (when liveness was seen), and
// MISS_LIMIT consecutive beat-less windows put the block into STALL, from
// which any `alive` recovers immediately with a beat.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        synchronous active-high reset, dominates everything
//   enable     block enable; low forces IDLE on the same edge
//   alive      liveness strobe from the control path
//   warning    watchdog pre-timeout warning (level); acted on at its rising edge
//   heartbeat  registered one-cycle pulse to the watchdog
//   stalled    high while in STALL
//   miss_cnt   consecutive missed windows, saturating at 255
//   beat_cnt   total heartbeats emitted, wraps modulo 2^16
// -----------------------------------------------------------------------------
module heartbeat_gen #(
    parameter int PERIOD     = 1000,
    parameter int MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        alive,
    input  logic        warning,
    output logic        heartbeat,
    output logic        stalled,
    output logic [7:0]  miss_cnt,
    output logic [15:0] beat_cnt
);

    localparam int               WIN_W    = $clog2(PERIOD);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PERIOD - 1);
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [7:0]       MISS_LIM = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIN_W-1:0] win_r;
    logic             alive_seen_r;
    logic             warn_prev_r;
    logic             heartbeat_r;
    logic             stalled_r;
    logic [7:0]       miss_cnt_r;
    logic [15:0]      beat_cnt_r;

    logic             eff_alive_s;
    logic             win_end_s;
    logic             warn_rise_s;
    logic             early_beat_s;
    logic [7:0]       miss_inc_s;

    // Saturating 8-bit increment for the miss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? 8'd255 : (v + 8'd1);
    endfunction

    // Per-cycle qualifiers derived from current state and inputs.
    always_comb begin
        eff_alive_s  = alive_seen_r | alive;
        win_end_s    = (win_r == WIN_LAST);
        warn_rise_s  = warning & ~warn_prev_r;
        // A warning edge right after a beat would stretch the pulse to two
        // cycles; it is ignored so the pulse stays exactly one cycle wide.
        early_beat_s = warn_rise_s & eff_alive_s & ~heartbeat_r;
        miss_inc_s   = sat_inc8(miss_cnt_r);
    end

    // Main state machine: window timing, beat decisions and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            win_r        <= WIN_ZERO;
            alive_seen_r <= 1'b0;
            warn_prev_r  <= 1'b0;
            heartbeat_r  <= 1'b0;
            stalled_r    <= 1'b0;
            miss_cnt_r   <= 8'd0;
            beat_cnt_r   <= 16'd0;
        end else begin
            warn_prev_r <= warning;
            heartbeat_r <= 1'b0;
            if (!enable) begin
                // Disable wins over any window end or recovery on this edge.
                state_r      <= ST_IDLE;
                win_r        <= WIN_ZERO;
                alive_seen_r <= 1'b0;
                miss_cnt_r   <= 8'd0;
                stalled_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // Enable edge: window starts counting on the next edge.
                        state_r      <= ST_RUN;
                        win_r        <= WIN_ZERO;
                        alive_seen_r <= 1'b0;
                        miss_cnt_r   <= 8'd0;
                        stalled_r    <= 1'b0;
                    end
                    ST_RUN: begin
                        if (win_end_s) begin
                            win_r        <= WIN_ZERO;
                            alive_seen_r <= 1'b0;
                            if (eff_alive_s) begin
                                heartbeat_r <= 1'b1;
                                miss_cnt_r  <= 8'd0;
                                beat_cnt_r  <= beat_cnt_r + 16'd1;
                                stalled_r   <= 1'b0;
                            end else begin
                                miss_cnt_r <= miss_inc_s;
                                if (miss_inc_s >= MISS_LIM) begin
                                    state_r   <= ST_STALL;
                                    stalled_r <= 1'b1;
                                end else begin
                                    stalled_r <= 1'b0;
                                end
                            end
                        end else if (early_beat_s) begin
                            heartbeat_r  <= 1'b1;
                            win_r        <= WIN_ZERO;
                            alive_seen_r <= 1'b0;
                            miss_cnt_r   <= 8'd0;
                            beat_cnt_r   <= beat_cnt_r + 16'd1;
                            stalled_r    <= 1'b0;
                        end else begin
                            win_r        <= win_r + WIN_ONE;
                            alive_seen_r <= eff_alive_s;
                            stalled_r    <= 1'b0;
                        end
                    end
                    ST_STALL: begin
                        if (alive) begin
                            // Immediate recovery: beat on the same edge.
                            state_r      <= ST_RUN;
                            heartbeat_r  <= 1'b1;
                            win_r        <= WIN_ZERO;
                            alive_seen_r <= 1'b0;
                            miss_cnt_r   <= 8'd0;
                            beat_cnt_r   <= beat_cnt_r + 16'd1;
                            stalled_r    <= 1'b0;
                        end else if (win_end_s) begin
                            win_r      <= WIN_ZERO;
                            miss_cnt_r <= miss_inc_s;
                            stalled_r  <= 1'b1;
                        end else begin
                            win_r     <= win_r + WIN_ONE;
                            stalled_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        win_r        <= WIN_ZERO;
                        alive_seen_r <= 1'b0;
                        miss_cnt_r   <= 8'd0;
                        stalled_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign heartbeat = heartbeat_r;
    assign stalled   = stalled_r;
    assign miss_cnt  = miss_cnt_r;
    assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_heartbeat_gen.sv
// -----------------------------------------------------------------------------
// tb_heartbeat_gen
//
// Directed scenarios followed by a randomized run, every cycle compared with a
// behavioural model that tracks windows by edge timestamps rather than a
// counter. PERIOD=8, MISS_LIMIT=2.
// -----------------------------------------------------------------------------
module tb_heartbeat_gen;

    localparam int P  = 8;
    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst, enable, alive, warning;
    logic        heartbeat, stalled;
    logic [7:0]  miss_cnt;
    logic [15:0] beat_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_mode = 0;      // 0 idle, 1 run, 2 stall
    int n      = 0;      // edge index
    int m_ws   = 0;      // edge at which the current window started
    bit m_seen = 1'b0;
    bit m_pw   = 1'b0;
    bit m_hb   = 1'b0;
    bit m_st   = 1'b0;
    int m_miss = 0;
    int m_beat = 0;

    heartbeat_gen #(.PERIOD(P), .MISS_LIMIT(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .alive     (alive),
        .warning   (warning),
        .heartbeat (heartbeat),
        .stalled   (stalled),
        .miss_cnt  (miss_cnt),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic give_beat();
        m_hb   = 1'b1;
        m_ws   = n;
        m_seen = 1'b0;
        m_miss = 0;
        m_beat = (m_beat + 1) % 65536;
    endtask

    task automatic ref_step(input bit r, input bit e, input bit a, input bit w);
        bit prev_hb, rise, eff, wend;
        n++;
        prev_hb = m_hb;
        m_hb    = 1'b0;
        if (r) begin
            m_mode = 0; m_seen = 0; m_pw = 0; m_st = 0; m_miss = 0; m_beat = 0;
        end else begin
            rise = w && !m_pw;
            m_pw = w;
            eff  = m_seen || a;
            wend = (n - m_ws) == P;
            if (!e) begin
                m_mode = 0; m_seen = 0; m_miss = 0; m_st = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_ws = n; m_seen = 0; m_st = 0;
            end else if (m_mode == 1) begin
                if (wend) begin
                    if (eff) give_beat();
                    else begin
                        m_ws = n; m_seen = 0; m_miss = sat(m_miss);
                        if (m_miss >= ML) m_mode = 2;
                    end
                end else if (rise && eff && !prev_hb) begin
                    give_beat();
                end else begin
                    m_seen = eff;
                end
                m_st = (m_mode == 2);
            end else begin
                if (a) begin
                    give_beat();
                    m_mode = 1;
                end else if (wend) begin
                    m_ws = n; m_miss = sat(m_miss);
                end
                m_st = (m_mode == 2);
            end
        end
    endtask

    // Drive inputs, clock one edge, update the model, compare all outputs.
    task automatic cyc(input bit r, input bit e, input bit a, input bit w);
        rst = r; enable = e; alive = a; warning = w;
        @(posedge clk);
        ref_step(r, e, a, w);
        #1;
        check("heartbeat", {31'd0, heartbeat}, {31'd0, m_hb});
        check("stalled",   {31'd0, stalled},   {31'd0, m_st});
        check("miss_cnt",  {24'd0, miss_cnt},  m_miss);
        check("beat_cnt",  {16'd0, beat_cnt},  m_beat);
    endtask

    initial begin
        bit re, ra, rw;
        int dens;
        rst = 1'b1; enable = 1'b0; alive = 1'b0; warning = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_hb", {31'd0, heartbeat}, 32'd0);
        check("rst_beat", {16'd0, beat_cnt}, 32'd0);

        // S1: four qualified windows, pulse every 8 edges
        cyc(0, 1, 0, 0);
        for (int wnd = 0; wnd < 4; wnd++)
            for (int k = 1; k <= 8; k++) begin
                cyc(0, 1, k == 3, 0);
                check("s1_pulse", {31'd0, heartbeat}, (k == 8) ? 32'd1 : 32'd0);
            end
        check("s1_beat", {16'd0, beat_cnt}, 32'd4);
        check("s1_miss", {24'd0, miss_cnt}, 32'd0);
        check("s1_stall", {31'd0, stalled}, 32'd0);

        // S2: starvation into STALL, then recovery
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 1, 0, 0);
            check("s2_nopulse", {31'd0, heartbeat}, 32'd0);
            if (k == 8) begin
                check("s2_miss1", {24'd0, miss_cnt}, 32'd1);
                check("s2_nostall", {31'd0, stalled}, 32'd0);
            end
            if (k == 16) begin
                check("s2_miss2", {24'd0, miss_cnt}, 32'd2);
                check("s2_stall", {31'd0, stalled}, 32'd1);
            end
        end
        cyc(0, 1, 1, 0);
        check("s2_recover_hb", {31'd0, heartbeat}, 32'd1);
        check("s2_recover_st", {31'd0, stalled}, 32'd0);
        check("s2_recover_miss", {24'd0, miss_cnt}, 32'd0);
        check("s2_beat", {16'd0, beat_cnt}, 32'd5);

        // S3: alive at cycle 2, warning edge at cycle 5 -> early beat
        for (int k = 1; k <= 5; k++) cyc(0, 1, k == 2, k == 5);
        check("s3_early", {31'd0, heartbeat}, 32'd1);
        check("s3_beat", {16'd0, beat_cnt}, 32'd6);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1, 0, 0);
            check("s3_nobeat", {31'd0, heartbeat}, 32'd0);
        end
        check("s3_miss", {24'd0, miss_cnt}, 32'd1);

        // S4: unqualified warning ignored; warning on qualified window end
        for (int k = 1; k <= 3; k++) cyc(0, 1, 0, k == 3);
        check("s4_ignored", {31'd0, heartbeat}, 32'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        check("s4_single_hb", {31'd0, heartbeat}, 32'd1);
        check("s4_beat", {16'd0, beat_cnt}, 32'd7);
        cyc(0, 1, 0, 1);
        check("s4_one_cycle", {31'd0, heartbeat}, 32'd0);
        check("s4_beat_once", {16'd0, beat_cnt}, 32'd7);

        // S5: enable dropped on qualified window end, then re-enable
        for (int k = 2; k <= 7; k++) cyc(0, 1, k == 4, 0);
        cyc(0, 0, 0, 0);
        check("s5_nopulse", {31'd0, heartbeat}, 32'd0);
        check("s5_miss", {24'd0, miss_cnt}, 32'd0);
        check("s5_beat", {16'd0, beat_cnt}, 32'd7);
        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1, k == 2, 0);
            check("s5_reen", {31'd0, heartbeat}, (k == 8) ? 32'd1 : 32'd0);
        end

        // S6: mid-window reset with beat_cnt=5, miss_cnt=1
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 40; k++) cyc(0, 1, (k % 8) == 1, 0);
        for (int k = 1; k <= 11; k++) cyc(0, 1, 0, 0);
        check("s6_pre_beat", {16'd0, beat_cnt}, 32'd5);
        check("s6_pre_miss", {24'd0, miss_cnt}, 32'd1);
        cyc(1, 1, 0, 0);
        check("s6_hb", {31'd0, heartbeat}, 32'd0);
        check("s6_st", {31'd0, stalled}, 32'd0);
        check("s6_miss", {24'd0, miss_cnt}, 32'd0);
        check("s6_beat", {16'd0, beat_cnt}, 32'd0);

        // Randomized run against the model
        re = 1'b1; rw = 1'b0; dens = 4;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 150) == 0) dens = $urandom_range(0, 3);
            if ($urandom_range(0, 59) == 0) re = ~re;
            if ($urandom_range(0, 4) == 0) rw = ~rw;
            case (dens)
                0: ra = 1'b0;
                1: ra = ($urandom_range(0, 11) == 0);
                2: ra = ($urandom_range(0, 2) == 0);
                default: ra = ($urandom_range(0, 6) == 0);
            endcase
            cyc($urandom_range(0, 399) == 0, re, ra, rw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
